temp_sample_filter: RTL and testbench

//  Consumes raw 16-bit temperature words from the SPI sensor sequencer.
//  A word is presented on each completed read_temp transfer.
//  The block keeps a moving average over 2**LOG2_DEPTH samples, tracks min/max since clear,
//  and drives an over-temperature alarm with hysteresis.

---
 rtl/temp_sample_filter.sv | 108 ++++++++++
 tb/tb_temp_sample_filter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/temp_sample_filter.sv
// rtl/temp_sample_filter.sv - moving-average temperature filter with min/max tracking and hysteretic alarm
module temp_sample_filter #(
  parameter int                 LOG2_DEPTH = 2,
  parameter logic signed [12:0] T_HIGH     = 13'sd480,
  parameter logic signed [12:0] T_LOW      = 13'sd448
) (
  input  logic        sys_clk_pin,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] sample_raw,
  input  logic        clear_stats,
  output logic [12:0] avg_temp,
  output logic        avg_valid,
  output logic        primed,
  output logic [12:0] min_temp,
  output logic [12:0] max_temp,
  output logic        stats_valid,
  output logic        alarm
);

  localparam int SW    = 13 + LOG2_DEPTH;
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FILL_FULL = (LOG2_DEPTH+1)'(DEPTH);

  typedef enum logic {IDLE, ALARM} state_t;

  state_t                  state;
  logic signed [12:0]      win_buf [DEPTH];
  logic [LOG2_DEPTH-1:0]   wp;
  logic [LOG2_DEPTH:0]     fill;
  logic signed [SW-1:0]    sum;
  logic                    upd_pending;

  logic signed [12:0]      t;
  logic signed [SW-1:0]    t_ext;
  logic signed [SW-1:0]    old_ext;
  logic signed [SW-1:0]    sum_shifted;
  logic signed [12:0]      avg_next;
  logic                    unused_flags;

  assign t            = $signed(sample_raw[15:3]);
  assign unused_flags = ^sample_raw[2:0];
  assign t_ext        = {{LOG2_DEPTH{t[12]}}, t};
  assign old_ext      = {{LOG2_DEPTH{win_buf[wp][12]}}, win_buf[wp]};
  assign sum_shifted  = sum >>> LOG2_DEPTH;
  assign avg_next     = sum_shifted[12:0];

  always_ff @(posedge sys_clk_pin) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) win_buf[i] <= '0;
      wp          <= '0;
      fill        <= '0;
      sum         <= '0;
      upd_pending <= 1'b0;
      primed      <= 1'b0;
      avg_temp    <= '0;
      avg_valid   <= 1'b0;
      min_temp    <= '0;
      max_temp    <= '0;
      stats_valid <= 1'b0;
      state       <= IDLE;
      alarm       <= 1'b0;
    end else begin
      upd_pending <= sample_valid;
      avg_valid   <= 1'b0;

      if (sample_valid) begin
        sum         <= sum + t_ext - old_ext;
        win_buf[wp] <= t;
        wp          <= wp + LOG2_DEPTH'(1);
        if (fill != FILL_FULL) fill <= fill + (LOG2_DEPTH+1)'(1);
        if (fill == FILL_FULL - (LOG2_DEPTH+1)'(1)) primed <= 1'b1;

        if (!stats_valid || clear_stats) begin
          min_temp <= t;
          max_temp <= t;
        end else begin
          if (t < $signed(min_temp)) min_temp <= t;
          if (t > $signed(max_temp)) max_temp <= t;
        end
        stats_valid <= 1'b1;
      end else if (clear_stats) begin
        stats_valid <= 1'b0;
      end

      // The average and the alarm decision both use the sum settled on the previous edge.
      if (upd_pending && primed) begin
        avg_temp  <= avg_next;
        avg_valid <= 1'b1;
        case (state)
          IDLE: if (avg_next > T_HIGH) begin
            state <= ALARM;
            alarm <= 1'b1;
          end
          ALARM: if (avg_next < T_LOW) begin
            state <= IDLE;
            alarm <= 1'b0;
          end
          default: begin
            state <= IDLE;
            alarm <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_temp_sample_filter.sv
// tb/tb_temp_sample_filter.sv - directed self-checking bench for temp_sample_filter
module tb_temp_sample_filter;

  logic        sys_clk_pin;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_raw;
  logic        clear_stats;
  logic [12:0] avg_temp;
  logic        avg_valid;
  logic        primed;
  logic [12:0] min_temp;
  logic [12:0] max_temp;
  logic        stats_valid;
  logic        alarm;

  int total = 0;
  int bad   = 0;

  temp_sample_filter dut (
    .sys_clk_pin (sys_clk_pin),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_raw  (sample_raw),
    .clear_stats (clear_stats),
    .avg_temp    (avg_temp),
    .avg_valid   (avg_valid),
    .primed      (primed),
    .min_temp    (min_temp),
    .max_temp    (max_temp),
    .stats_valid (stats_valid),
    .alarm       (alarm)
  );

  initial sys_clk_pin = 1'b0;
  always #5 sys_clk_pin = ~sys_clk_pin;

  // One clock: drive inputs, take the edge, release strobes 1 time unit after it.
  task automatic cyc(input logic v, input logic [15:0] raw, input logic clr, input logic r);
    sample_valid = v;
    sample_raw   = raw;
    clear_stats  = clr;
    rst          = r;
    @(posedge sys_clk_pin);
    #1;
    sample_valid = 1'b0;
    clear_stats  = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1'b1, 16'h0FA0, 1'b0, 1'b1);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    total++; if (avg_temp !== 13'd0)   begin bad++; $display("FAIL reset_avg got=%0d want=0", avg_temp); end
    total++; if (avg_valid !== 1'b0)   begin bad++; $display("FAIL reset_avg_valid got=%b want=0", avg_valid); end
    total++; if (primed !== 1'b0)      begin bad++; $display("FAIL reset_primed got=%b want=0", primed); end
    total++; if (min_temp !== 13'd0)   begin bad++; $display("FAIL reset_min got=%0d want=0", min_temp); end
    total++; if (max_temp !== 13'd0)   begin bad++; $display("FAIL reset_max got=%0d want=0", max_temp); end
    total++; if (stats_valid !== 1'b0) begin bad++; $display("FAIL reset_stats_valid got=%b want=0", stats_valid); end
    total++; if (alarm !== 1'b0)       begin bad++; $display("FAIL reset_alarm got=%b want=0", alarm); end
  endtask

  task automatic test_priming();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h0C80, 1'b0, 1'b0);
      total++; if (primed !== 1'b0)    begin bad++; $display("FAIL prime_early_primed[%0d] got=%b want=0", i, primed); end
      total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL prime_early_avg_valid[%0d] got=%b want=0", i, avg_valid); end
    end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL prime_idle_avg_valid got=%b want=0", avg_valid); end
    cyc(1'b1, 16'h0C80, 1'b0, 1'b0);
    total++; if (primed !== 1'b1)    begin bad++; $display("FAIL prime_fourth_primed got=%b want=1", primed); end
    total++; if (avg_valid !== 1'b0) begin bad++; $display("FAIL prime_latency_early got=%b want=0", avg_valid); end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (avg_valid !== 1'b1)  begin bad++; $display("FAIL prime_avg_valid got=%b want=1", avg_valid); end
    total++; if (avg_temp !== 13'd400) begin bad++; $display("FAIL prime_avg got=%0d want=400", $signed(avg_temp)); end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (avg_valid !== 1'b0)  begin bad++; $display("FAIL prime_pulse_width got=%b want=0", avg_valid); end
    total++; if (avg_temp !== 13'd400) begin bad++; $display("FAIL prime_avg_hold got=%0d want=400", $signed(avg_temp)); end
  endtask

  task automatic test_negative_window();
    logic signed [12:0] exp_min;
    logic signed [12:0] exp_max;
    exp_min = -13'sd160;
    exp_max = 13'sd400;
    cyc(1'b1, 16'hFB00, 1'b0, 1'b0);
    total++; if (min_temp !== exp_min) begin bad++; $display("FAIL neg_min got=%0d want=-160", $signed(min_temp)); end
    total++; if (max_temp !== exp_max) begin bad++; $display("FAIL neg_max got=%0d want=400", $signed(max_temp)); end
    total++; if (stats_valid !== 1'b1) begin bad++; $display("FAIL neg_stats_valid got=%b want=1", stats_valid); end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (avg_valid !== 1'b1)   begin bad++; $display("FAIL neg_avg_valid got=%b want=1", avg_valid); end
    total++; if (avg_temp !== 13'd260) begin bad++; $display("FAIL neg_avg got=%0d want=260", $signed(avg_temp)); end
  endtask

  task automatic test_back_to_back_alarm();
    int exp_avg [12] = '{285, 310, 335, 500, 490, 480, 470, 460, 455, 450, 445, 440};
    logic exp_alarm [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] raw;
    logic signed [12:0] exp_min;
    for (int j = 0; j <= 12; j++) begin
      raw = (j < 4) ? 16'h0FA0 : (j < 8) ? 16'h0E60 : 16'h0DC0;
      cyc(j < 12, raw, 1'b0, 1'b0);
      if (j >= 1) begin
        total++; if (avg_valid !== 1'b1) begin bad++; $display("FAIL b2b_avg_valid[%0d] got=%b want=1", j-1, avg_valid); end
        total++; if ($signed(avg_temp) !== 13'(exp_avg[j-1])) begin bad++; $display("FAIL b2b_avg[%0d] got=%0d want=%0d", j-1, $signed(avg_temp), exp_avg[j-1]); end
        total++; if (alarm !== exp_alarm[j-1]) begin bad++; $display("FAIL b2b_alarm[%0d] got=%b want=%b", j-1, alarm, exp_alarm[j-1]); end
      end
    end
    exp_min = -13'sd160;
    total++; if (min_temp !== exp_min)  begin bad++; $display("FAIL b2b_min got=%0d want=-160", $signed(min_temp)); end
    total++; if (max_temp !== 13'd500)  begin bad++; $display("FAIL b2b_max got=%0d want=500", $signed(max_temp)); end
  endtask

  task automatic test_clear_stats();
    cyc(1'b1, 16'h1000, 1'b1, 1'b0);
    total++; if (min_temp !== 13'd512)  begin bad++; $display("FAIL clr_seed_min got=%0d want=512", $signed(min_temp)); end
    total++; if (max_temp !== 13'd512)  begin bad++; $display("FAIL clr_seed_max got=%0d want=512", $signed(max_temp)); end
    total++; if (stats_valid !== 1'b1)  begin bad++; $display("FAIL clr_seed_stats_valid got=%b want=1", stats_valid); end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    total++; if (stats_valid !== 1'b0)  begin bad++; $display("FAIL clr_alone_stats_valid got=%b want=0", stats_valid); end
    total++; if (avg_temp !== 13'd458)  begin bad++; $display("FAIL clr_avg got=%0d want=458", $signed(avg_temp)); end
    total++; if (alarm !== 1'b0)        begin bad++; $display("FAIL clr_alarm got=%b want=0", alarm); end
  endtask

  task automatic test_reset_mid_stream();
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'h0FA0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0320, 1'b0, 1'b0);
    total++; if (alarm !== 1'b1)      begin bad++; $display("FAIL rstmid_pre_alarm got=%b want=1", alarm); end
    cyc(1'b0, 16'h0000, 1'b0, 1'b1);
    total++; if (avg_valid !== 1'b0)  begin bad++; $display("FAIL rstmid_avg_valid got=%b want=0", avg_valid); end
    total++; if (primed !== 1'b0)     begin bad++; $display("FAIL rstmid_primed got=%b want=0", primed); end
    total++; if (alarm !== 1'b0)      begin bad++; $display("FAIL rstmid_alarm got=%b want=0", alarm); end
    total++; if (avg_temp !== 13'd0)  begin bad++; $display("FAIL rstmid_avg got=%0d want=0", $signed(avg_temp)); end
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0320, 1'b0, 1'b0);
    total++; if (primed !== 1'b0)     begin bad++; $display("FAIL rstmid_reprime_early got=%b want=0", primed); end
    cyc(1'b1, 16'h0320, 1'b0, 1'b0);
    total++; if (primed !== 1'b1)     begin bad++; $display("FAIL rstmid_reprimed got=%b want=1", primed); end
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (avg_valid !== 1'b1)  begin bad++; $display("FAIL rstmid_new_avg_valid got=%b want=1", avg_valid); end
    total++; if (avg_temp !== 13'd100) begin bad++; $display("FAIL rstmid_new_avg got=%0d want=100", $signed(avg_temp)); end
  endtask

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    sample_raw   = 16'h0000;
    clear_stats  = 1'b0;
    test_reset();
    test_priming();
    test_negative_window();
    test_back_to_back_alarm();
    test_clear_stats();
    test_reset_mid_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
